// File: rtl/vco_adc_multich_counter_if.sv
// Result stream port of the multi-channel VCO counter: one beat per reported channel,
// moved on out_valid && out_ready.
interface vco_adc_multich_counter_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 12
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;

    modport master (output out_valid, out_data, out_ch, input out_ready);
    modport slave  (input out_valid, out_data, out_ch, output out_ready);
endinterface

// File: rtl/vco_adc_multich_counter.sv
// Counts rising edges of NUM_CH asynchronous VCO outputs over a programmable window and
// drains the per-channel snapshots, lowest index first, through a valid/ready stream.
module vco_adc_multich_counter #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 12,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clock,
    input  logic                      resetb,
    input  logic [NUM_CH-1:0]         vco_in,
    input  logic                      en,
    input  logic                      start,
    input  logic                      mode_cont,
    input  logic [WIN_W-1:0]          win_len,
    input  logic [NUM_CH-1:0]         ch_mask,
    vco_adc_multich_counter_if.master out_if,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH-1:0]         overflow
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] sync_p [SYNC_STAGES];
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] edge_pulse;
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  snap_q [NUM_CH];
    logic [WIN_W-1:0]  wcnt_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_rest;
    logic [NUM_CH-1:0] ovf_q;
    logic              done_q;
    logic [CH_W-1:0]   cur_ch;
    logic              xfer;
    logic              load_win, clr_ovf, count_en, snap_en, done_d, last_beat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != '1)) return v + 1'b1;
        return v;
    endfunction

    function automatic logic [CH_W-1:0] low_idx(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) r = CH_W'(i);
        return r;
    endfunction

    // Stage: input synchronisers and rising-edge detect (pin to increment = SYNC_STAGES+1)
    always_ff @(posedge clock) begin
        if (!resetb) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_p[0] <= vco_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            prev_q <= sync_p[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_p[SYNC_STAGES-1] & ~prev_q;

    // Pending-channel set: the lowest set bit is the beat on offer, clearing it advances
    assign cur_ch    = low_idx(pend_q);
    assign pend_rest = pend_q & (pend_q - 1'b1);

    assign out_if.out_valid = (state_q == DRAIN) && (pend_q != '0);
    assign out_if.out_ch    = cur_ch;
    assign out_if.out_data  = snap_q[cur_ch];
    assign xfer             = out_if.out_valid && out_if.out_ready;

    always_comb begin
        state_d   = state_q;
        load_win  = 1'b0;
        clr_ovf   = 1'b0;
        count_en  = 1'b0;
        snap_en   = 1'b0;
        done_d    = 1'b0;
        last_beat = (pend_q == '0) || (xfer && (pend_rest == '0));
        case (state_q)
            IDLE: begin
                if (start && en) begin
                    state_d  = COUNT;
                    load_win = 1'b1;
                    clr_ovf  = 1'b1;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    count_en = 1'b1;
                    if (wcnt_q == WIN_W'(1)) begin
                        snap_en = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_beat) begin
                    done_d = 1'b1;
                    if (mode_cont && en) begin
                        state_d  = COUNT;
                        load_win = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage: window counting, snapshot and drain bookkeeping
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (clr_ovf) ovf_q <= '0;
            if (load_win) begin
                wcnt_q <= (win_len == '0) ? WIN_W'(1) : win_len;
                mask_q <= ch_mask;
                for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            end else if (count_en) begin
                wcnt_q <= wcnt_q - 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt_q[i] <= sat_inc(cnt_q[i], edge_pulse[i]);
                    if (edge_pulse[i] && (cnt_q[i] == '1)) ovf_q[i] <= 1'b1;
                end
            end
            // The final window cycle's edges go straight into the snapshot
            if (snap_en) begin
                for (int i = 0; i < NUM_CH; i++) snap_q[i] <= sat_inc(cnt_q[i], edge_pulse[i]);
                pend_q <= mask_q;
            end else if (xfer) begin
                pend_q <= pend_rest;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
endmodule
